// File: rtl/ysyx_25040129_wbu_pkg.sv
// Shared definitions for the write-back stage: widths, CSR map, mstatus fields,
// FSM encodings and the CSR update request passed to the CSR file.
package ysyx_25040129_wbu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REGS_DIG = 5;
  localparam int unsigned CSR_DIG  = 3;

  localparam logic [CSR_DIG-1:0] CSR_MSTATUS   = CSR_DIG'(0);
  localparam logic [CSR_DIG-1:0] CSR_MTVEC     = CSR_DIG'(1);
  localparam logic [CSR_DIG-1:0] CSR_MEPC      = CSR_DIG'(2);
  localparam logic [CSR_DIG-1:0] CSR_MCAUSE    = CSR_DIG'(3);
  localparam logic [CSR_DIG-1:0] CSR_MVENDORID = CSR_DIG'(4);
  localparam logic [CSR_DIG-1:0] CSR_MARCHID   = CSR_DIG'(5);

  localparam logic [XLEN-1:0] MSTATUS_RESET  = 32'h0000_1800;
  localparam logic [XLEN-1:0] MVENDORID_VAL  = 32'h7973_7978;
  localparam logic [XLEN-1:0] MARCHID_VAL    = 32'h017E_1501;
  localparam logic [XLEN-1:0] MCAUSE_ECALL_M = 32'd11;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_REDIRECT = 2'd1;
  localparam logic [STATE_W-1:0] ST_HALTED   = 2'd2;

  // One cycle's worth of CSR side effects, already qualified by accept and priority.
  typedef struct packed {
    logic               wen;
    logic [CSR_DIG-1:0] addr;
    logic [XLEN-1:0]    wdata;
    logic               ecall;
    logic               mret;
    logic [XLEN-1:0]    pc;
  } csr_req_t;

  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/ysyx_25040129_wbu_csr_file.sv
// Machine-mode CSR file: writable trap CSRs, read-only ID registers,
// trap entry/exit side effects and a combinational read port.
module ysyx_25040129_csr_file
  import ysyx_25040129_wbu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  csr_req_t           req,
  input  logic [CSR_DIG-1:0] raddr,
  output logic [XLEN-1:0]    rdata,
  output logic [XLEN-1:0]    mtvec,
  output logic [XLEN-1:0]    mepc
);

  logic [XLEN-1:0] mstatus_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;

  // Trap entry outranks mret, which outranks an explicit CSR write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mstatus_q <= MSTATUS_RESET;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else if (req.ecall) begin
      mstatus_q <= mstatus_on_trap(mstatus_q);
      mepc_q    <= req.pc;
      mcause_q  <= MCAUSE_ECALL_M;
    end else if (req.mret) begin
      mstatus_q <= mstatus_on_mret(mstatus_q);
    end else if (req.wen) begin
      case (req.addr)
        CSR_MSTATUS: mstatus_q <= req.wdata;
        CSR_MTVEC:   mtvec_q   <= req.wdata;
        CSR_MEPC:    mepc_q    <= req.wdata;
        CSR_MCAUSE:  mcause_q  <= req.wdata;
        default:     ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (raddr)
      CSR_MSTATUS:   rdata = mstatus_q;
      CSR_MTVEC:     rdata = mtvec_q;
      CSR_MEPC:      rdata = mepc_q;
      CSR_MCAUSE:    rdata = mcause_q;
      CSR_MVENDORID: rdata = MVENDORID_VAL;
      CSR_MARCHID:   rdata = MARCHID_VAL;
      default:       rdata = '0;
    endcase
  end

  assign mtvec = mtvec_q;
  assign mepc  = mepc_q;

endmodule

// File: rtl/ysyx_25040129_wbu.sv
// Write-back/commit stage: GPR write port, CSR updates, IFU redirects,
// fence.i flush pulse and the sticky ebreak halt.
module ysyx_25040129_wbu
  import ysyx_25040129_wbu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                is_req_valid_from_lsu,
  output logic                is_req_ready_to_lsu,
  input  logic [XLEN-1:0]     pc_in_wbu,
  input  logic [XLEN-1:0]     result_in_wbu,
  input  logic                reg_write_in_wbu,
  input  logic [REGS_DIG-1:0] rd_in_wbu,
  input  logic                csr_write_in_wbu,
  input  logic [CSR_DIG-1:0]  csr_addr_in_wbu,
  input  logic [XLEN-1:0]     csr_wdata_in_wbu,
  input  logic                is_branch_in_wbu,
  input  logic [XLEN-1:0]     branch_target_in_wbu,
  input  logic                ecall_in_wbu,
  input  logic                mret_in_wbu,
  input  logic                ebreak_in_wbu,
  input  logic                fence_i_in_wbu,
  output logic                rf_wen,
  output logic [REGS_DIG-1:0] rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  input  logic [CSR_DIG-1:0]  csr_raddr,
  output logic [XLEN-1:0]     csr_rdata,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc,
  input  logic                redirect_ready,
  output logic                icache_flush,
  output logic                inst_commit,
  output logic                halt
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               accept;
  logic               take_ecall, take_mret, take_branch, take_fence;
  logic               redirect_d, flush_d, commit_d, halt_d;
  logic [XLEN-1:0]    redirect_pc_d;
  logic [XLEN-1:0]    mtvec, mepc;
  csr_req_t           csr_req;

  assign is_req_ready_to_lsu = (state_q == ST_IDLE);
  assign accept              = is_req_valid_from_lsu && is_req_ready_to_lsu;

  // Only the highest-priority control class acts.
  assign take_ecall  = ecall_in_wbu;
  assign take_mret   = !ecall_in_wbu && mret_in_wbu;
  assign take_branch = !ecall_in_wbu && !mret_in_wbu && is_branch_in_wbu;
  assign take_fence  = !ecall_in_wbu && !mret_in_wbu && !is_branch_in_wbu && fence_i_in_wbu;

  assign rf_wen   = accept && reg_write_in_wbu && (rd_in_wbu != '0);
  assign rf_waddr = rd_in_wbu;
  assign rf_wdata = result_in_wbu;

  assign csr_req.wen   = accept && csr_write_in_wbu && !ecall_in_wbu && !mret_in_wbu;
  assign csr_req.addr  = csr_addr_in_wbu;
  assign csr_req.wdata = csr_wdata_in_wbu;
  assign csr_req.ecall = accept && take_ecall;
  assign csr_req.mret  = accept && take_mret;
  assign csr_req.pc    = pc_in_wbu;

  ysyx_25040129_csr_file u_csr_file (
    .clk   (clk),
    .rst   (rst),
    .req   (csr_req),
    .raddr (csr_raddr),
    .rdata (csr_rdata),
    .mtvec (mtvec),
    .mepc  (mepc)
  );

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc;
    flush_d       = 1'b0;
    commit_d      = 1'b0;
    halt_d        = halt;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          commit_d = 1'b1;
          flush_d  = take_fence;
          if (ebreak_in_wbu) begin
            state_d = ST_HALTED;
            halt_d  = 1'b1;
          end else if (take_ecall || take_mret || take_branch || take_fence) begin
            state_d    = ST_REDIRECT;
            redirect_d = 1'b1;
            if (take_ecall)       redirect_pc_d = mtvec;
            else if (take_mret)   redirect_pc_d = mepc;
            else if (take_branch) redirect_pc_d = branch_target_in_wbu;
            else                  redirect_pc_d = pc_in_wbu + 32'd4;
          end
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) state_d = ST_IDLE;
        else                redirect_d = 1'b1;
      end
      ST_HALTED: halt_d = 1'b1;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      icache_flush   <= 1'b0;
      inst_commit    <= 1'b0;
      halt           <= 1'b0;
    end else begin
      state_q        <= state_d;
      redirect_valid <= redirect_d;
      redirect_pc    <= redirect_pc_d;
      icache_flush   <= flush_d;
      inst_commit    <= commit_d;
      halt           <= halt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_wbu.sv
// Bench for the write-back stage: directed scenarios plus random instructions
// checked against an architectural model of the CSRs and redirect rules.
module tb_ysyx_25040129_wbu;
  import ysyx_25040129_wbu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid, ready;
  logic [31:0] pc, result, csr_wdata, br_tgt, csr_rdata, redirect_pc, rf_wdata;
  logic        reg_write, csr_write, is_branch, ecall, mret, ebreak, fence_i;
  logic [4:0]  rd, rf_waddr;
  logic [2:0]  csr_addr, csr_raddr;
  logic        rf_wen, redirect_valid, redirect_ready, icache_flush, inst_commit, halt;

  ysyx_25040129_wbu dut (
    .clk(clk), .rst(rst),
    .is_req_valid_from_lsu(valid), .is_req_ready_to_lsu(ready),
    .pc_in_wbu(pc), .result_in_wbu(result), .reg_write_in_wbu(reg_write), .rd_in_wbu(rd),
    .csr_write_in_wbu(csr_write), .csr_addr_in_wbu(csr_addr), .csr_wdata_in_wbu(csr_wdata),
    .is_branch_in_wbu(is_branch), .branch_target_in_wbu(br_tgt),
    .ecall_in_wbu(ecall), .mret_in_wbu(mret), .ebreak_in_wbu(ebreak), .fence_i_in_wbu(fence_i),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .icache_flush(icache_flush), .inst_commit(inst_commit), .halt(halt)
  );

  typedef struct {
    logic [31:0] pc, result, cwdata, tgt;
    logic        rw, cw, br, ec, mr, fe;
    logic [4:0]  rd;
    logic [2:0]  caddr;
  } ins_t;

  int tests = 0;
  int failed = 0;
  logic [31:0] m_csr [0:3];  // mstatus, mtvec, mepc, mcause

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input int idx);
    if (idx <= 3) return m_csr[idx];
    if (idx == 4) return 32'h7973_7978;
    if (idx == 5) return 32'h017E_1501;
    return 32'h0;
  endfunction

  task automatic m_reset();
    m_csr[0] = 32'h0000_1800;
    m_csr[1] = 32'h0;
    m_csr[2] = 32'h0;
    m_csr[3] = 32'h0;
  endtask

  function automatic ins_t blank(input logic [31:0] p);
    ins_t i;
    i.pc = p; i.result = 32'h0; i.cwdata = 32'h0; i.tgt = 32'h0;
    i.rw = 1'b0; i.cw = 1'b0; i.br = 1'b0; i.ec = 1'b0; i.mr = 1'b0; i.fe = 1'b0;
    i.rd = 5'd0; i.caddr = 3'd0;
    return i;
  endfunction

  task automatic drive(input ins_t i);
    valid = 1'b1; pc = i.pc; result = i.result; reg_write = i.rw; rd = i.rd;
    csr_write = i.cw; csr_addr = i.caddr; csr_wdata = i.cwdata;
    is_branch = i.br; br_tgt = i.tgt; ecall = i.ec; mret = i.mr; fence_i = i.fe; ebreak = 1'b0;
  endtask

  task automatic rd_csr(input int idx, input string tag);
    csr_raddr = 3'(idx);
    #1;
    chk(tag, csr_rdata, m_read(idx));
  endtask

  // Issue one instruction starting at a negedge; returns at a negedge with the WBU idle.
  task automatic issue(input ins_t i, input int delay, input string tag);
    logic        exp_redir, exp_flush;
    logic [31:0] exp_pc, ms;
    int          ra;
    drive(i);
    ra = int'($urandom_range(0, 7));
    csr_raddr = 3'(ra);
    #1;
    chk({tag, ".ready"}, 32'(ready), 32'd1);
    chk({tag, ".rf_wen"}, 32'(rf_wen), 32'(i.rw && i.rd != 5'd0));
    if (i.rw && i.rd != 5'd0) begin
      chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(i.rd));
      chk({tag, ".rf_wdata"}, rf_wdata, i.result);
    end
    chk({tag, ".csr_rd_old"}, csr_rdata, m_read(ra));
    exp_redir = 1'b1; exp_flush = 1'b0; exp_pc = 32'h0;
    if (i.ec)      exp_pc = m_csr[1];
    else if (i.mr) exp_pc = m_csr[2];
    else if (i.br) exp_pc = i.tgt;
    else if (i.fe) begin exp_pc = i.pc + 32'd4; exp_flush = 1'b1; end
    else           exp_redir = 1'b0;
    if (i.ec) begin
      ms = m_csr[0]; ms[7] = ms[3]; ms[3] = 1'b0; ms[12:11] = 2'b11;
      m_csr[0] = ms; m_csr[2] = i.pc; m_csr[3] = 32'd11;
    end else if (i.mr) begin
      ms = m_csr[0]; ms[3] = ms[7]; ms[7] = 1'b1; m_csr[0] = ms;
    end else if (i.cw && i.caddr <= 3'd3) begin
      m_csr[i.caddr] = i.cwdata;
    end
    @(negedge clk);
    valid = 1'b0;
    chk({tag, ".commit"}, 32'(inst_commit), 32'd1);
    chk({tag, ".flush"}, 32'(icache_flush), 32'(exp_flush));
    chk({tag, ".redir_v"}, 32'(redirect_valid), 32'(exp_redir));
    chk({tag, ".ready_after"}, 32'(ready), 32'(!exp_redir));
    if (exp_redir) begin
      chk({tag, ".redir_pc"}, redirect_pc, exp_pc);
      for (int k = 0; k < delay; k++) begin
        @(negedge clk);
        chk({tag, ".hold_v"}, 32'(redirect_valid), 32'd1);
        chk({tag, ".hold_pc"}, redirect_pc, exp_pc);
        chk({tag, ".hold_pulses"}, 32'({inst_commit, icache_flush}), 32'd0);
      end
      redirect_ready = 1'b1;
      @(negedge clk);
      redirect_ready = 1'b0;
      chk({tag, ".redir_done"}, 32'(redirect_valid), 32'd0);
      chk({tag, ".ready_back"}, 32'(ready), 32'd1);
    end
  endtask

  initial begin
    ins_t i;
    rst = 1'b0; redirect_ready = 1'b0; csr_raddr = 3'd0;
    drive(blank(32'h0)); valid = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst.redir_v", 32'(redirect_valid), 32'd0);
    chk("rst.redir_pc", redirect_pc, 32'd0);
    chk("rst.pulses", 32'({inst_commit, icache_flush}), 32'd0);
    chk("rst.halt", 32'(halt), 32'd0);
    chk("rst.ready", 32'(ready), 32'd1);
    rd_csr(0, "rst.mstatus");
    rd_csr(4, "rst.mvendorid");
    rst = 1'b1;
    @(negedge clk);

    // back-to-back GPR writes; rd=0 is suppressed
    i = blank(32'h8000_0000); i.rw = 1'b1; i.rd = 5'd5; i.result = 32'h1234;
    issue(i, 0, "addi5");
    i = blank(32'h8000_0004); i.rw = 1'b1; i.rd = 5'd0; i.result = 32'hDEAD;
    issue(i, 0, "addi0");

    // trap entry with a slow IFU
    i = blank(32'h8000_0008); i.cw = 1'b1; i.caddr = 3'd1; i.cwdata = 32'h8000_0100;
    issue(i, 0, "csrw_mtvec");
    i = blank(32'h8000_0040); i.ec = 1'b1;
    issue(i, 3, "ecall");
    rd_csr(2, "ecall.mepc");
    rd_csr(3, "ecall.mcause");
    rd_csr(0, "ecall.mstatus");

    // mret with MPIE preset
    @(negedge clk);
    i = blank(32'h8000_0100); i.cw = 1'b1; i.caddr = 3'd0; i.cwdata = 32'h0000_1880;
    issue(i, 0, "csrw_mstatus");
    i = blank(32'h8000_0104); i.mr = 1'b1;
    issue(i, 1, "mret");
    rd_csr(0, "mret.mstatus");

    // taken branch with immediate IFU accept, then an immediate next instruction
    @(negedge clk);
    i = blank(32'h8000_0044); i.br = 1'b1; i.tgt = 32'h8000_0200;
    issue(i, 0, "branch");
    i = blank(32'h8000_0200); i.rw = 1'b1; i.rd = 5'd9; i.result = 32'h55AA;
    issue(i, 0, "after_branch");

    i = blank(32'h8000_0010); i.fe = 1'b1;
    issue(i, 2, "fence_i");

    // read-only and unmapped CSR writes are dropped
    i = blank(32'h8000_0014); i.cw = 1'b1; i.caddr = 3'd5; i.cwdata = 32'hFFFF_FFFF;
    issue(i, 0, "csrw_marchid");
    i = blank(32'h8000_0018); i.cw = 1'b1; i.caddr = 3'd6; i.cwdata = 32'h1357_9BDF;
    issue(i, 0, "csrw_unmapped");
    rd_csr(5, "marchid");
    rd_csr(6, "unmapped");

    // random instruction mix, including overlapping classes
    @(negedge clk);
    for (int n = 0; n < 80; n++) begin
      i = blank($urandom & 32'hFFFF_FFFC);
      i.result = $urandom; i.rw = 1'($urandom); i.rd = 5'($urandom);
      i.cw = ($urandom_range(0, 2) == 0); i.caddr = 3'($urandom); i.cwdata = $urandom;
      i.tgt = $urandom; i.br = ($urandom_range(0, 5) == 0);
      i.ec = ($urandom_range(0, 7) == 0); i.mr = ($urandom_range(0, 7) == 0);
      i.fe = ($urandom_range(0, 7) == 0);
      issue(i, int'($urandom_range(0, 3)), "rand");
    end
    for (int c = 0; c < 4; c++) rd_csr(c, "rand.csr");

    // reset while a redirect is pending
    @(negedge clk);
    i = blank(32'h8000_0300); i.br = 1'b1; i.tgt = 32'h8000_0400;
    drive(i);
    @(negedge clk);
    valid = 1'b0;
    chk("rstredir.pending", 32'(redirect_valid), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    chk("rstredir.valid", 32'(redirect_valid), 32'd0);
    chk("rstredir.ready", 32'(ready), 32'd1);
    rd_csr(0, "rstredir.mstatus");

    // ebreak still performs its writes, then halts
    @(negedge clk);
    i = blank(32'h8000_0500); i.rw = 1'b1; i.rd = 5'd7; i.result = 32'hABCD;
    i.cw = 1'b1; i.caddr = 3'd2; i.cwdata = 32'h0000_1234;
    drive(i);
    ebreak = 1'b1;
    #1;
    chk("ebreak.rf_wen", 32'(rf_wen), 32'd1);
    m_csr[2] = 32'h0000_1234;
    @(negedge clk);
    ebreak = 1'b0;
    i = blank(32'h8000_0504); i.rw = 1'b1; i.rd = 5'd3;
    drive(i);
    chk("ebreak.commit", 32'(inst_commit), 32'd1);
    chk("ebreak.halt", 32'(halt), 32'd1);
    rd_csr(2, "ebreak.mepc");
    repeat (3) @(negedge clk);
    chk("halted.ready", 32'(ready), 32'd0);
    chk("halted.rf_wen", 32'(rf_wen), 32'd0);
    chk("halted.halt", 32'(halt), 32'd1);
    chk("halted.commit", 32'(inst_commit), 32'd0);
    valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("unhalt.halt", 32'(halt), 32'd0);
    chk("unhalt.ready", 32'(ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ysyx_25040129_wbu.md
# ysyx_25040129_wbu

Write-back/commit stage of the ysyx_25040129 core, directly downstream of the LSU. Accepts one retired instruction per valid/ready handshake and performs all architectural updates. Updates are the GPR write port, the machine-mode CSR file, trap entry/exit, and redirects to the IFU (taken branch, ecall, mret, fence.i). It also provides the combinational CSR read port used by the EXU and the ebreak halt signal.

## Interface
- No parameters; widths come from the shared package (`REGS_DIG`, `CSR_DIG`).
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- is_req_valid_from_lsu  in  1  LSU holds a retired instruction
- is_req_ready_to_lsu  out  1  WBU can accept
- pc_in_wbu  in  32  PC of the instruction
- result_in_wbu  in  32  GPR write data (load data or ALU result)
- reg_write_in_wbu  in  1  instruction writes rd
- rd_in_wbu  in  REGS_DIG  destination GPR
- csr_write_in_wbu  in  1  instruction writes a CSR
- csr_addr_in_wbu  in  CSR_DIG  CSR index (package encoding)
- csr_wdata_in_wbu  in  32  CSR write data
- is_branch_in_wbu  in  1  control transfer taken, redirect to branch_target_in_wbu
- branch_target_in_wbu  in  32  redirect target
- ecall_in_wbu, mret_in_wbu, ebreak_in_wbu, fence_i_in_wbu  in  1 each  instruction class
- rf_wen  out  1  GPR write enable
- rf_waddr  out  REGS_DIG  GPR write address
- rf_wdata  out  32  GPR write data
- csr_raddr  in  CSR_DIG  CSR read index
- csr_rdata  out  32  CSR read data, combinational
- redirect_valid  out  1  new fetch PC offered to IFU
- redirect_pc  out  32  new fetch PC
- redirect_ready  in  1  IFU accepts redirect
- icache_flush  out  1  one-cycle pulse on fence.i acceptance
- inst_commit  out  1  registered one-cycle pulse per retired instruction
- halt  out  1  sticky; set by ebreak

## Operation
- States: IDLE, REDIRECT, HALTED.
- `is_req_ready_to_lsu` = (state==IDLE).
- accept = valid && ready. All architectural writes happen at the accept edge.
- GPR write: `rf_wen = accept && reg_write_in_wbu && rd_in_wbu!=0`. `rf_waddr`/`rf_wdata` pass through rd/result.
- CSRs (package indices):
  - MSTATUS=0: reset 0x0000_1800
  - MTVEC=1: reset 0
  - MEPC=2: reset 0
  - MCAUSE=3: reset 0
  - MVENDORID=4: RO 0x7973_7978
  - MARCHID=5: RO 0x017E_1501
  - Writes to RO or unmapped indices are dropped. Unmapped reads return 0.
- ecall: mepc←pc, mcause←11, mstatus.MPIE←MIE, MIE←0, MPP←2'b11; redirect to mtvec (pre-write value).
- mret: MIE←MPIE, MPIE←1; redirect to current mepc.
- Class priority (only the winner acts): ecall > mret > is_branch > fence_i. csr_write is suppressed when ecall or mret is set. The GPR write is never suppressed.
- fence_i: `icache_flush` pulses in the cycle after accept; redirect to pc+4.
- Any redirect: latch the target into `redirect_pc`, go to REDIRECT. Hold `redirect_valid`=1 and a stable PC until `redirect_ready`, then return to IDLE.
- ebreak: all writes of that instruction still occur, then go to HALTED. In HALTED, `halt`=1 and ready=0 until reset.
- CSR read has no bypass. A read in the accept cycle of a write returns the old value.

## Timing
- Non-redirecting instruction: 1-cycle occupancy, back-to-back accepts allowed.
- Redirect: accept edge → `redirect_valid` high the next cycle. Minimum 2 cycles per instruction.
- `inst_commit` and `icache_flush` are asserted exactly one cycle after the accept edge.
- Reset values: `redirect_valid`, `redirect_pc`, `icache_flush`, `inst_commit`, `halt` are 0; state is IDLE; CSRs take their reset values. `rf_wen` is 0 whenever ready=0.
- Reset asserted in REDIRECT or HALTED: next edge goes to IDLE, `redirect_valid` drops, and the pending redirect is lost.
- `redirect_ready` asserted in the first REDIRECT cycle: return to IDLE the next edge.

## Structure
- Shared package/defines hold:
  - CSR index constants and CSR_DIG
  - mcause code 11
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11)
  - RO ID values
  - state encodings
- One sub-module, `ysyx_25040129_csr_file`, containing the CSR registers, the read mux, and the trap/mret update logic. The WBU keeps the FSM and redirect latch.

## Test plan
- addi result 0x1234 to rd=5, then rd=0 back-to-back → rf_wen pulses for rd=5 only; ready stays 1; two inst_commit pulses.
- csrw mtvec=0x8000_0100, then ecall at pc 0x8000_0040 → mepc=0x8000_0040, mcause=11, mstatus=0x1800 with MIE=0; redirect_pc=0x8000_0100 held while redirect_ready=0 for 3 cycles.
- mret after ecall, with MPIE=1 preset via csrw → redirect_pc=mepc, MIE=1.
- Taken branch to 0x8000_0200 with redirect_ready=1 immediately → redirect_valid for exactly 1 cycle; next instruction accepted 2 cycles after the first.
- fence.i at pc 0x8000_0010 → icache_flush single pulse; redirect_pc=0x8000_0014.
- csrw to marchid, then read it → 0x017E_1501. ebreak → halt=1, ready=0 indefinitely. Reset low mid-REDIRECT → idle next cycle, redirect_valid=0.
